// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: write/commit port of the seven-segment scan controller.
interface seg_scan_ctrl_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       wr_dp;
   logic       commit;
   logic       pending;
   modport master (output wr_valid, wr_addr, wr_data, wr_dp, commit, input wr_ready, pending);
   modport slave (input wr_valid, wr_addr, wr_data, wr_dp, commit, output wr_ready, pending);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered, time-multiplexed scan controller for a common-anode 7-seg bank.
module seg_scan_ctrl #(
   parameter int NDIG  = 8,
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic                 clk,
   input  logic                 clrn,
   seg_scan_ctrl_if.slave       bus,
   input  logic [7:0]           dig_en,
   input  logic                 lz_en,
   output logic [7:0]           an,
   output logic [6:0]           seg,
   output logic                 dp,
   output logic                 frame_start
);
   localparam int CW = $clog2(DIV);
   typedef enum logic {P_BLANK, P_SHOW} phase_t;
   phase_t          r_phase;
   logic [CW-1:0]   r_cyc;
   logic [2:0]      r_dig;
   logic            r_pending;
   logic [7:0][3:0] r_sh_nib, r_ac_nib;
   logic [7:0]      r_sh_dp, r_ac_dp;
   logic [7:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_dp, r_fs;
   logic            w_wrap, w_last_dig, w_boundary, w_wr, w_lz, w_show;
   logic [7:0]      w_nz;
   logic [6:0]      w_seg;
   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      case (h)
         4'h0: hex2seg = 7'b1000000;
         4'h1: hex2seg = 7'b1111001;
         4'h2: hex2seg = 7'b0100100;
         4'h3: hex2seg = 7'b0110000;
         4'h4: hex2seg = 7'b0011001;
         4'h5: hex2seg = 7'b0010010;
         4'h6: hex2seg = 7'b0000010;
         4'h7: hex2seg = 7'b1111000;
         4'h8: hex2seg = 7'b0000000;
         4'h9: hex2seg = 7'b0010000;
         4'hA: hex2seg = 7'b0001000;
         4'hB: hex2seg = 7'b0000011;
         4'hC: hex2seg = 7'b1000110;
         4'hD: hex2seg = 7'b0100001;
         4'hE: hex2seg = 7'b0000110;
         default: hex2seg = 7'b0001110;
      endcase
   endfunction
   assign w_wrap     = r_cyc == CW'(DIV - 1);
   assign w_last_dig = r_dig == 3'(NDIG - 1);
   assign w_boundary = w_wrap & w_last_dig;
   assign w_wr       = bus.wr_valid & ~r_pending & ({1'b0, bus.wr_addr} < 4'(NDIG));
   always_comb begin
      w_nz = '0;
      for (int k = 0; k < 8; k++) w_nz[k] = (|r_ac_nib[k]) | r_ac_dp[k];
   end
   // Slots at or above NDIG are never written, so their zero entries never defeat suppression.
   assign w_lz   = lz_en & (r_dig != 3'd0) & ((w_nz >> r_dig) == 8'd0);
   assign w_show = (r_phase == P_SHOW) & dig_en[r_dig] & ~w_lz;
   assign w_seg  = hex2seg(r_ac_nib[r_dig]);
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cyc     <= '0;
         r_dig     <= '0;
         r_phase   <= P_BLANK;
         r_pending <= 1'b0;
         r_sh_nib  <= '0;
         r_sh_dp   <= '0;
         r_ac_nib  <= '0;
         r_ac_dp   <= '0;
         r_an      <= 8'hFF;
         r_seg     <= 7'h7F;
         r_dp      <= 1'b1;
         r_fs      <= 1'b0;
      end else begin
         r_cyc   <= w_wrap ? '0 : r_cyc + 1'b1;
         r_dig   <= w_wrap ? (w_last_dig ? 3'd0 : r_dig + 3'd1) : r_dig;
         r_phase <= w_wrap ? P_BLANK : (r_cyc == CW'(BLANK - 1)) ? P_SHOW : r_phase;
         if (w_wr) begin
            r_sh_nib[bus.wr_addr] <= bus.wr_data;
            r_sh_dp[bus.wr_addr]  <= bus.wr_dp;
         end
         // The shadow is frozen while pending, so the copy always sees the committed image.
         if (w_boundary & r_pending) begin
            r_ac_nib  <= r_sh_nib;
            r_ac_dp   <= r_sh_dp;
            r_pending <= 1'b0;
         end else if (bus.commit) begin
            r_pending <= 1'b1;
         end
         r_an  <= w_show ? ~(8'd1 << r_dig) : 8'hFF;
         r_seg <= w_show ? w_seg : 7'h7F;
         r_dp  <= w_show ? ~r_ac_dp[r_dig] : 1'b1;
         r_fs  <= (r_cyc == '0) & (r_dig == 3'd0);
      end
   end
   assign bus.wr_ready = ~r_pending;
   assign bus.pending  = r_pending;
   assign an           = r_an;
   assign seg          = r_seg;
   assign dp           = r_dp;
   assign frame_start  = r_fs;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's common-anode seven-segment display bank. It owns a double-buffered digit store that the system loads through a valid/ready write port. It steps one digit at a time through the shared hex-to-seven-segment decoder (hex2seg), with anti-ghost blanking and optional leading-zero suppression. It sits between the CPU/debug register interface and the display pins, and is the only driver of `an`, `seg` and `dp`.

## Interface
- NDIG, 8, number of digits scanned (2..8); digit index width is fixed at 3 bits.
- DIV, 50000, clock cycles per digit slot (≥ BLANK+2).
- BLANK, 16, cycles at the start of each slot with all anodes off (≥1).
- clk  in  1  system clock, all state on rising edge.
- clrn  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when `wr_valid & wr_ready`.
- wr_addr  in  3  digit index; indices ≥ NDIG are accepted and discarded.
- wr_data  in  4  hex nibble.
- wr_dp  in  1  decimal point for that digit, 1 = lit.
- commit  in  1  single-cycle pulse: copy the shadow bank to the active bank at the next frame boundary.
- dig_en  in  8  per-digit enable; bit k = 0 blanks digit k.
- lz_en  in  1  leading-zero suppression enable.
- an  out  8  anode selects, active-low; bits ≥ NDIG are held 1.
- seg  out  7  segments {g..a}, active-low, hex2seg encoding (0 → 7'b1000000).
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0.
- pending  out  1  a commit is waiting for the frame boundary.

## Operation
- Shadow bank: NDIG × {nibble, dp}. Written on accepted writes. Readback is not supported.
- Active bank: NDIG × {nibble, dp}. Drives the display. Written only by the commit copy.
- `wr_ready = ~pending`. While a commit is pending, the shadow bank is frozen.
- `commit` while `pending = 1` is ignored.
- `commit` with an accepted write in the same cycle: the write lands in the shadow bank first, and the copy sees it.
- Frame boundary is the last cycle of slot NDIG-1. On that cycle, if pending: active ← shadow, pending ← 0.
- Scan state:
  - `cyc` counts 0..DIV-1.
  - `dig` counts 0..NDIG-1. It increments when `cyc` wraps and wraps to 0 after NDIG-1.
- Phase FSM per slot:
  - BLANK while `cyc < BLANK`.
  - SHOW while `BLANK ≤ cyc ≤ DIV-1`.
  - BLANK → SHOW at `cyc = BLANK`.
  - SHOW → BLANK at the `cyc` wrap.
- BLANK phase outputs: `an = 8'hFF`, `seg = 7'h7F`, `dp = 1`.
- SHOW phase: `an[dig] = 0`, `seg = hex2seg(active[dig].nibble)`, `dp = ~active[dig].dp`.
- SHOW phase is blanked instead (same values as BLANK phase) if either holds:
  - `dig_en[dig] = 0`; or
  - `lz_en = 1`, `dig ≠ 0`, and active nibbles dig..NDIG-1 are all zero and their dp bits are all 0.
- Digit 0 is never suppressed by lz_en.
- `dig_en` and `lz_en` are sampled live each cycle; no commit is needed.

## Timing
- Reset values:
  - `an = 8'hFF`, `seg = 7'h7F`, `dp = 1`.
  - `frame_start = 0`, `pending = 0`, `wr_ready = 1`.
  - `cyc = 0`, `dig = 0`, both banks all zero.
- `an`, `seg`, `dp` and `frame_start` are registered: they reflect the counter state of the previous cycle.
- After reset release:
  - First `frame_start` pulse is at cycle 1.
  - First anode is asserted at cycle BLANK+1.
- Frame length is exactly NDIG·DIV cycles.
- `frame_start` repeats with period NDIG·DIV.
- Commit-to-display latency:
  - Copy happens on the frame-boundary cycle.
  - New values appear on pins from slot 0 of the next frame.
  - `pending` is low in the cycle after the copy.
  - Worst case is NDIG·DIV+1 cycles.
- Write accept is combinational on `wr_ready`. The shadow update is visible to a commit copy on the next edge.
- Reset asserted mid-frame immediately forces all outputs to their reset values and discards any pending commit.

## Test plan
All scenarios use NDIG=4, DIV=6, BLANK=2 unless stated.
- Reset/idle:
  - Stimulus: hold clrn=0 for 3 cycles, then release.
  - Required: `an = FF` and `seg = 7F` during reset; `frame_start` at cycle 1; `an = 4'b1110` (upper bits 1) from cycle 3 to 6, with `seg = 1000000`.
- Write+commit:
  - Stimulus: write digits 0..3 = A, 1, 2, 3 (dp on digit 1); pulse commit mid-frame.
  - Required: `pending = 1` and `wr_ready = 0` until the boundary; next frame shows `seg = 0001000`, then `1111001` with `dp = 0`, then `0100100`, then `0110000`.
- Write blocked while pending:
  - Stimulus: assert `wr_valid` with addr 2 = F while `pending = 1`.
  - Required: not accepted; digit 2 still shows 2 after the commit.
- Leading-zero suppression:
  - Stimulus: active = 0, 5, 0, 0; `lz_en = 1`.
  - Required: digits 3 and 2 blanked; digit 1 shows `0010010`; digit 0 shows `1000000`.
  - Then set digit 3's dp: digits 3 and 2 both display.
- Mask and blanking:
  - Stimulus: `dig_en = 4'b1011`.
  - Required: digit 2's slot shows `an = FF` for its full 6 cycles; every slot has exactly 2 all-off cycles at its start.
- Reset mid-operation:
  - Stimulus: assert clrn during slot 2 with `pending = 1`.
  - Required: outputs return to reset values within the same cycle; `pending = 0`; display shows all zeros after release.
